// File: rtl/fpu_dot2.sv
// fpu_dot2: sequential binary32 two-term dot product g = a*b + c*d.
// One shared multiplier and one adder are sequenced by IDLE->MUL1->MUL2->ADD->DONE.
// Build option FPU_ROUND_EN: defined selects round-to-nearest-even with overflow to inf;
// undefined selects round-toward-zero with overflow saturating to max finite.
module fpu_dot2 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        fi,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] g
);

`ifdef FPU_ROUND_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, MUL1, MUL2, ADD, DONE} state_t;

    state_t      state, state_nxt;
    logic        fi_nxt, cap;
    logic [31:0] ra, rb, rc, rd, p1, p2;
    logic [31:0] mul_x, mul_y, mul_r, add_r;

    // Round a normalized mantissa {1,frac} with guard/sticky, then handle overflow and flush.
    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e_in,
                                         input logic [23:0] m_in, input logic grd,
                                         input logic stk);
        logic signed [9:0] e;
        logic [24:0]       mr;
        logic [22:0]       frac;
        logic              inc;
        e    = e_in;
        inc  = RNE && grd && (stk || m_in[0]);
        mr   = {1'b0, m_in} + 25'(inc);
        frac = mr[22:0];
        if (mr[24]) begin
            frac = mr[23:1];
            e    = e + 10'sd1;
        end
        if (e >= 10'sd255)
            return RNE ? {s, 8'hFF, 23'd0} : {s, 8'hFE, 23'h7F_FFFF};
        if (e <= 10'sd0)
            return {s, 31'd0};
        return {s, e[7:0], frac};
    endfunction

    // binary32 multiply with denormal flush and special-value handling.
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic              s, xz, yz, xi, yi, xn, yn;
        logic [47:0]       p;
        logic signed [9:0] e;
        s  = x[31] ^ y[31];
        xz = (x[30:23] == 8'h00);
        yz = (y[30:23] == 8'h00);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        if (xn || yn) return QNAN;
        if ((xi && yz) || (yi && xz)) return QNAN;
        if (xi || yi) return {s, 8'hFF, 23'd0};
        if (xz || yz) return {s, 31'd0};
        p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
        e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
        if (p[47])
            return pack(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
        return pack(s, e, p[46:23], p[22], |p[21:0]);
    endfunction

    // binary32 add: align with guard/round/sticky, normalize on carry or cancellation.
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic              xz, yz, xi, yi, xn, yn;
        logic [31:0]       big, sml;
        logic [26:0]       mb, ms, al, n;
        logic [27:0]       sum;
        logic [7:0]        dd;
        logic signed [9:0] e;
        int                lz;
        xz = (x[30:23] == 8'h00);
        yz = (y[30:23] == 8'h00);
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        if (xn || yn) return QNAN;
        if (xi && yi) return (x[31] != y[31]) ? QNAN : x;
        if (xi) return x;
        if (yi) return y;
        if (xz && yz) return {x[31] & y[31], 31'd0};
        if (xz) return y;
        if (yz) return x;
        if (x[30:0] >= y[30:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        mb = {1'b1, big[22:0], 3'b000};
        ms = {1'b1, sml[22:0], 3'b000};
        dd = big[30:23] - sml[30:23];
        if (dd >= 8'd27)
            al = 27'd1;
        else
            al = (ms >> dd) | 27'(|(ms & ~(27'h7FF_FFFF << dd)));
        if (big[31] != sml[31])
            sum = {1'b0, mb} - {1'b0, al};
        else
            sum = {1'b0, mb} + {1'b0, al};
        if (sum == 28'd0) return 32'h0000_0000;
        e = $signed({2'b00, big[30:23]});
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = e + 10'sd1;
        end else begin
            lz = 0;
            for (int i = 0; i < 27; i++)
                if (sum[i]) lz = 26 - i;
            n = sum[26:0] << lz;
            e = e - 10'(lz);
        end
        return pack(big[31], e, n[26:3], n[2], |n[1:0]);
    endfunction

    // Shared multiplier operand select: term 2 only in MUL2.
    always_comb begin
        mul_x = ra;
        mul_y = rb;
        if (state == MUL2) begin
            mul_x = rc;
            mul_y = rd;
        end
    end

    assign mul_r = fmul(mul_x, mul_y);
    assign add_r = fadd(p1, p2);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state, capture strobe and finish flag.
    always_comb begin
        state_nxt = state;
        fi_nxt    = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE: if (en) begin
                cap       = 1'b1;
                state_nxt = MUL1;
            end
            MUL1: state_nxt = MUL2;
            MUL2: state_nxt = ADD;
            ADD:  state_nxt = DONE;
            DONE: begin
                if (en) fi_nxt    = 1'b1;
                else    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, partial products, result and finish flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fi <= 1'b0;
            g  <= 32'h0000_0000;
            ra <= 32'h0;
            rb <= 32'h0;
            rc <= 32'h0;
            rd <= 32'h0;
            p1 <= 32'h0;
            p2 <= 32'h0;
        end else begin
            fi <= fi_nxt;
            if (cap) begin
                ra <= a;
                rb <= b;
                rc <= c;
                rd <= d;
            end
            if (state == MUL1) p1 <= mul_r;
            if (state == MUL2) p2 <= mul_r;
            if (state == ADD)  g  <= add_r;
        end
    end

endmodule

// File: tb/tb_fpu_dot2.sv
// Testbench for fpu_dot2: scoreboard of expected g values, one task per scenario.
module tb_fpu_dot2;

    logic        clk, rst, en, fi;
    logic [31:0] a, b, c, d, g;

    typedef struct packed {
        logic [31:0] a, b, c, d, g;
    } vec_t;

    logic [31:0] sb_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

`ifdef FPU_ROUND_EN
    localparam logic [31:0] OVF_POS = 32'h7F80_0000;
    localparam logic [31:0] OVF_NEG = 32'hFF80_0000;
    localparam logic [31:0] TIE_UP  = 32'h3F80_0001;
`else
    localparam logic [31:0] OVF_POS = 32'h7F7F_FFFF;
    localparam logic [31:0] OVF_NEG = 32'hFF7F_FFFF;
    localparam logic [31:0] TIE_UP  = 32'h3F80_0000;
`endif

    fpu_dot2 dut (
        .clk(clk), .rst(rst), .en(en), .fi(fi),
        .a(a), .b(b), .c(c), .d(d), .g(g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands with en high and record the expected result.
    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic [31:0] tc, input logic [31:0] td,
                            input logic [31:0] exp_g);
        @(negedge clk);
        a = ta; b = tb_v; c = tc; d = td;
        en = 1'b1;
        sb_q.push_back(exp_g);
    endtask

    // Count edges (including the capture edge) until fi, scrambling inputs after capture.
    task automatic wait_fi(output int unsigned edges, output bit got);
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (fi) got = 1'b1;
            a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        end
    endtask

    // Release en and let DONE exit.
    task automatic finish_op();
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0;
        a = 32'h0; b = 32'h0; c = 32'h0; d = 32'h0;
        @(posedge clk); #1;
        checks++;
        if (fi !== 1'b0) begin errors++; $display("FAIL reset_fi: got %b want 0", fi); end
        checks++;
        if (g !== 32'h0) begin errors++; $display("FAIL reset_g: got %h want 00000000", g); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int unsigned edges; bit got; logic [31:0] exp_g;
        start_op(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 32'h4000_0000);
        wait_fi(edges, got);
        exp_g = sb_q.pop_front();
        checks++;
        if (!got || edges != 5) begin
            errors++; $display("FAIL basic_latency: got %0d edges (fi=%b) want 4 after capture", edges - 1, got);
        end
        checks++;
        if (g !== exp_g) begin errors++; $display("FAIL basic_g: got %h want %h", g, exp_g); end
        finish_op();
        checks++;
        if (fi !== 1'b0) begin errors++; $display("FAIL basic_fi_drop: got %b want 0", fi); end
    endtask

    task automatic test_arith();
        vec_t vecs[$];
        int unsigned edges; bit got; logic [31:0] exp_g;
        vecs.push_back({32'h4000_0000, 32'h4040_0000, 32'h3F00_0000, 32'hC080_0000, 32'h4080_0000});
        vecs.push_back({32'h3FC0_0000, 32'h4000_0000, 32'hC040_0000, 32'h3F80_0000, 32'h0000_0000});
        vecs.push_back({32'h7F00_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, OVF_POS});
        vecs.push_back({32'hFF00_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000, OVF_NEG});
        vecs.push_back({32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000});
        vecs.push_back({32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7FC0_0000});
        vecs.push_back({32'h7F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7F80_0000});
        vecs.push_back({32'h7F80_0000, 32'h3F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h7FC0_0000});
        vecs.push_back({32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000});
        vecs.push_back({32'h0000_0001, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000});
        vecs.push_back({32'h3F80_0000, 32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0000, TIE_UP});
        vecs.push_back({32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back({32'hC000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hC0A0_0000});
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].g);
            wait_fi(edges, got);
            exp_g = sb_q.pop_front();
            checks++;
            if (!got || edges != 5) begin
                errors++; $display("FAIL arith%0d_latency: got %0d edges (fi=%b) want 4", i, edges - 1, got);
            end
            checks++;
            if (g !== exp_g) begin errors++; $display("FAIL arith%0d_g: got %h want %h", i, g, exp_g); end
            finish_op();
        end
    endtask

    task automatic test_hold();
        int unsigned edges; bit got; logic [31:0] exp_g; bit bad;
        start_op(32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h40A0_0000);
        wait_fi(edges, got);
        exp_g = sb_q.pop_front();
        checks++;
        if (!got || g !== exp_g) begin errors++; $display("FAIL hold_first: got %h fi=%b want %h", g, got, exp_g); end
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (fi !== 1'b1 || g !== exp_g) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL hold_stable: got fi=%b g=%h want fi=1 g=%h", fi, g, exp_g); end
        finish_op();
        checks++;
        if (fi !== 1'b0) begin errors++; $display("FAIL hold_fi_drop: got %b want 0", fi); end
    endtask

    task automatic test_en_drop();
        logic [31:0] exp_g; bit seen;
        start_op(32'h4040_0000, 32'h4040_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4100_0000);
        @(posedge clk); #1;
        en = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (fi) seen = 1'b1;
        end
        exp_g = sb_q.pop_front();
        checks++;
        if (seen) begin errors++; $display("FAIL endrop_fi: got fi=1 want fi never high"); end
        checks++;
        if (g !== exp_g) begin errors++; $display("FAIL endrop_g: got %h want %h", g, exp_g); end
    endtask

    task automatic test_reset_abort();
        int unsigned edges; bit got; logic [31:0] exp_g;
        @(negedge clk);
        a = 32'h4000_0000; b = 32'h4000_0000; c = 32'h4000_0000; d = 32'h4000_0000;
        en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (fi !== 1'b0) begin errors++; $display("FAIL abort_fi: got %b want 0", fi); end
        checks++;
        if (g !== 32'h0) begin errors++; $display("FAIL abort_g: got %h want 00000000", g); end
        @(negedge clk);
        rst = 1'b1; en = 1'b0;
        start_op(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h0000_0000, 32'h4000_0000);
        wait_fi(edges, got);
        exp_g = sb_q.pop_front();
        checks++;
        if (!got || edges != 5) begin
            errors++; $display("FAIL abort_rerun_latency: got %0d edges (fi=%b) want 4", edges - 1, got);
        end
        checks++;
        if (g !== exp_g) begin errors++; $display("FAIL abort_rerun_g: got %h want %h", g, exp_g); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_arith();
        test_hold();
        test_en_drop();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
